output_argmax: RTL and testbench

OUTPUT_ARGMAX -- requirements
Module: output_argmax

---
 rtl/nn_pkg.sv | 27 ++
 rtl/argmax_node.sv | 23 ++
 rtl/output_argmax.sv | 169 ++++++++++++++++
 tb/tb_output_argmax.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and elaboration helpers for the classifier output stage.
package nn_pkg;

  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultClasses   = 10;

  function automatic int unsigned nn_clog2(input int unsigned value);
    int unsigned result = 0;
    int unsigned span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // Candidates left after `level` halving rounds; an odd count keeps its bye.
  function automatic int unsigned level_count(input int unsigned classes,
                                              input int unsigned level);
    int unsigned n = classes;
    for (int unsigned i = 0; i < level; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// Combinational tournament node: picks the larger signed score of two candidates.
module argmax_node
  import nn_pkg::*;
#(
  parameter int unsigned SCORE_W = 2 * DefaultDataWidth,
  parameter int unsigned IDX_W   = nn_clog2(DefaultClasses)
) (
  input  logic [SCORE_W-1:0] a_score_i,
  input  logic [IDX_W-1:0]   a_idx_i,
  input  logic [SCORE_W-1:0] b_score_i,
  input  logic [IDX_W-1:0]   b_idx_i,
  output logic [SCORE_W-1:0] win_score_o,
  output logic [IDX_W-1:0]   win_idx_o
);

  logic b_wins;

  // Slot a always holds the lower class indices, so a tie keeps a.
  assign b_wins      = $signed(b_score_i) > $signed(a_score_i);
  assign win_score_o = b_wins ? b_score_i : a_score_i;
  assign win_idx_o   = b_wins ? b_idx_i : a_idx_i;

endmodule

// File: rtl/output_argmax.sv
// Pipelined argmax over the final-layer scores; one result per done_in rising edge.
// Define OUTPUT_ARGMAX_SCORE_EN to also export the winning score on max_score.
module output_argmax
  import nn_pkg::*;
#(
  parameter int unsigned CLASSES    = DefaultClasses,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  localparam int unsigned LEVELS    = nn_clog2(CLASSES),
  localparam int unsigned IDX_W     = (LEVELS > 0) ? LEVELS : 1,
  localparam int unsigned SCORE_W   = 2 * DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done_in,
  input  logic [CLASSES*SCORE_W-1:0] in,
  output logic [IDX_W-1:0]           out,
  output logic                       out_valid
`ifdef OUTPUT_ARGMAX_SCORE_EN
  ,
  output logic [SCORE_W-1:0]         max_score
`endif
);

  if (CLASSES < 2 || CLASSES > 64) begin : g_bad_classes
    $error("output_argmax: CLASSES must be in 2..64");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("output_argmax: DATA_WIDTH must be at least 1");
  end

  logic done_prev_q;
  logic start;

  assign start = done_in & ~done_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= done_in;
    end
  end

  // cur_* is the registered candidate set entering each level; win_* leaves it.
  logic [SCORE_W-1:0] cur_score [LEVELS][CLASSES];
  logic [IDX_W-1:0]   cur_idx   [LEVELS][CLASSES];
  logic [LEVELS-1:0]  cur_valid;
  logic [SCORE_W-1:0] win_score [LEVELS][CLASSES];
  logic [IDX_W-1:0]   win_idx   [LEVELS][CLASSES];

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int unsigned N = level_count(CLASSES, l);

    logic [SCORE_W-1:0] score_q [N];
    logic               valid_q;

    if (l == 0) begin : g_capture
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= start;
        end
      end

      always_ff @(posedge clk) begin
        if (start) begin
          for (int j = 0; j < N; j++) begin
            score_q[j] <= in[j*SCORE_W +: SCORE_W];
          end
        end
      end

      for (genvar j = 0; j < CLASSES; j++) begin : g_idx
        assign cur_idx[l][j] = IDX_W'(j);
      end
    end else begin : g_stage
      logic [IDX_W-1:0] idx_q [N];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= cur_valid[l-1];
        end
      end

      always_ff @(posedge clk) begin
        if (cur_valid[l-1]) begin
          for (int j = 0; j < N; j++) begin
            score_q[j] <= win_score[l-1][j];
            idx_q[j]   <= win_idx[l-1][j];
          end
        end
      end

      for (genvar j = 0; j < CLASSES; j++) begin : g_idx
        if (j < N) begin : g_live
          assign cur_idx[l][j] = idx_q[j];
        end else begin : g_dead
          assign cur_idx[l][j] = '0;
        end
      end
    end

    assign cur_valid[l] = valid_q;

    for (genvar j = 0; j < CLASSES; j++) begin : g_slot
      if (j < N) begin : g_live
        assign cur_score[l][j] = score_q[j];
      end else begin : g_dead
        assign cur_score[l][j] = '0;
      end

      if (2 * j + 1 < N) begin : g_pair
        argmax_node #(
          .SCORE_W (SCORE_W),
          .IDX_W   (IDX_W)
        ) u_node (
          .a_score_i   (cur_score[l][2*j]),
          .a_idx_i     (cur_idx[l][2*j]),
          .b_score_i   (cur_score[l][2*j+1]),
          .b_idx_i     (cur_idx[l][2*j+1]),
          .win_score_o (win_score[l][j]),
          .win_idx_o   (win_idx[l][j])
        );
      end else if (2 * j < N) begin : g_bye
        assign win_score[l][j] = cur_score[l][2*j];
        assign win_idx[l][j]   = cur_idx[l][2*j];
      end else begin : g_none
        assign win_score[l][j] = '0;
        assign win_idx[l][j]   = '0;
      end
    end
  end

  logic [IDX_W-1:0] out_q;
  logic             out_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= cur_valid[LEVELS-1];
      if (cur_valid[LEVELS-1]) begin
        out_q <= win_idx[LEVELS-1][0];
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef OUTPUT_ARGMAX_SCORE_EN
  logic [SCORE_W-1:0] max_score_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_score_q <= '0;
    end else if (cur_valid[LEVELS-1]) begin
      max_score_q <= win_score[LEVELS-1][0];
    end
  end

  assign max_score = max_score_q;
`endif

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax at CLASSES = 10, 7 and 2.
module tb_output_argmax;

  logic         clk = 1'b0;
  logic         rst;
  logic         done10;
  logic         done_s;
  logic [319:0] in10;
  logic [223:0] in7;
  logic [63:0]  in2;
  logic [3:0]   out10;
  logic [2:0]   out7;
  logic [0:0]   out2;
  logic         v10, v7, v2;
`ifdef OUTPUT_ARGMAX_SCORE_EN
  logic [31:0]  sc10, sc7, sc2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  output_argmax #(.CLASSES(10), .DATA_WIDTH(16)) dut10 (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done10),
    .in        (in10),
    .out       (out10),
    .out_valid (v10)
`ifdef OUTPUT_ARGMAX_SCORE_EN
    ,
    .max_score (sc10)
`endif
  );

  output_argmax #(.CLASSES(7), .DATA_WIDTH(16)) dut7 (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_s),
    .in        (in7),
    .out       (out7),
    .out_valid (v7)
`ifdef OUTPUT_ARGMAX_SCORE_EN
    ,
    .max_score (sc7)
`endif
  );

  output_argmax #(.CLASSES(2), .DATA_WIDTH(16)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .done_in   (done_s),
    .in        (in2),
    .out       (out2),
    .out_valid (v2)
`ifdef OUTPUT_ARGMAX_SCORE_EN
    ,
    .max_score (sc2)
`endif
  );

  typedef struct {
    logic [319:0] vec;
    logic [3:0]   idx;
    logic [31:0]  score;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [319:0] fill10(input logic [31:0] v);
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [223:0] fill7(input logic [31:0] v);
    logic [223:0] r;
    for (int k = 0; k < 7; k++) r[k*32 +: 32] = v;
    return r;
  endfunction

  task automatic run_small(input logic [223:0] vec7, input logic [2:0] i7,
                           input logic [31:0] s7, input logic [63:0] vec2,
                           input logic [0:0] i2, input logic [31:0] s2, input string tag);
    in7    = vec7;
    in2    = vec2;
    done_s = 1'b1;
    step();
    done_s = 1'b0;
    in7    = ~vec7;
    in2    = ~vec2;
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("%s_c7_valid_c%0d", tag, c), 64'(v7), 64'(c == 3));
      chk($sformatf("%s_c2_valid_c%0d", tag, c), 64'(v2), 64'(c == 1));
      if (c >= 3) chk($sformatf("%s_c7_out_c%0d", tag, c), 64'(out7), 64'(i7));
      if (c >= 1) chk($sformatf("%s_c2_out_c%0d", tag, c), 64'(out2), 64'(i2));
`ifdef OUTPUT_ARGMAX_SCORE_EN
      if (c == 3) chk($sformatf("%s_c7_score", tag), 64'(sc7), 64'(s7));
      if (c == 1) chk($sformatf("%s_c2_score", tag), 64'(sc2), 64'(s2));
`endif
    end
    // Expected scores only feed the optional max_score checks.
    if (s7 === 32'hx || s2 === 32'hx) $display("note: unknown expected score");
  endtask

  task automatic check_dual(input int c);
    chk($sformatf("dual_valid_c%0d", c), 64'(v10), 64'(c == 4 || c == 6));
    if (c == 4 || c == 5) chk($sformatf("dual_out_c%0d", c), 64'(out10), 64'd6);
    if (c == 6 || c == 7) chk($sformatf("dual_out_c%0d", c), 64'(out10), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [319:0] va;
    logic [319:0] vb;
    logic [223:0] v7a;
    logic [63:0]  v2a;
    int           pulses;
    int           pulse_c;
    logic [3:0]   pulse_out;

    // Directed table: CLASSES=10, hand-computed winners.
    for (int k = 0; k < 10; k++) tbl[0].vec[k*32 +: 32] = 32'(k * 100);
    tbl[0].idx = 4'd9; tbl[0].score = 32'd900;
    tbl[1].vec = fill10(32'hFFFF_FFFB);
    tbl[1].vec[3*32 +: 32] = 32'hFFFF_FFFF;
    tbl[1].idx = 4'd3; tbl[1].score = 32'hFFFF_FFFF;
    tbl[2].vec = fill10(32'd7);
    tbl[2].idx = 4'd0; tbl[2].score = 32'd7;
    tbl[3].vec = fill10(32'hFFFF_0000);
    tbl[3].vec[0*32 +: 32] = 32'h8000_0000;
    tbl[3].vec[4*32 +: 32] = 32'h7FFF_FFFF;
    tbl[3].idx = 4'd4; tbl[3].score = 32'h7FFF_FFFF;
    tbl[4].vec = fill10(32'd10);
    tbl[4].vec[5*32 +: 32] = 32'd50;
    tbl[4].vec[8*32 +: 32] = 32'd50;
    tbl[4].idx = 4'd5; tbl[4].score = 32'd50;
    tbl[5].vec = fill10(32'hFFFF_FFFE);
    tbl[5].vec[8*32 +: 32] = 32'd1;
    tbl[5].idx = 4'd8; tbl[5].score = 32'd1;

    rst    = 1'b1;
    done10 = 1'b0;
    done_s = 1'b0;
    in10   = '0;
    in7    = '0;
    in2    = '0;
    step();
    step();
    chk("rst_out10", 64'(out10), 64'd0);
    chk("rst_valid10", 64'(v10), 64'd0);
    chk("rst_out7", 64'(out7), 64'd0);
    chk("rst_valid7", 64'(v7), 64'd0);
    chk("rst_out2", 64'(out2), 64'd0);
    chk("rst_valid2", 64'(v2), 64'd0);
`ifdef OUTPUT_ARGMAX_SCORE_EN
    chk("rst_score10", 64'(sc10), 64'd0);
`endif
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      in10   = tbl[i].vec;
      done10 = 1'b1;
      step();
      chk($sformatf("tbl%0d_valid_c0", i), 64'(v10), 64'd0);
      done10 = 1'b0;
      in10   = ~tbl[i].vec;
      for (int c = 1; c <= 5; c++) begin
        step();
        chk($sformatf("tbl%0d_valid_c%0d", i, c), 64'(v10), 64'(c == 4));
        if (c >= 4) chk($sformatf("tbl%0d_out_c%0d", i, c), 64'(out10), 64'(tbl[i].idx));
`ifdef OUTPUT_ARGMAX_SCORE_EN
        if (c == 4) chk($sformatf("tbl%0d_score", i), 64'(sc10), 64'(tbl[i].score));
`endif
      end
    end

    // Signed extremes with the winner in the last slot, then all-minimum ties.
    v7a = fill7(32'h8000_0000);
    v7a[6*32 +: 32] = 32'h7FFF_FFFF;
    v2a = {32'h7FFF_FFFF, 32'h8000_0000};
    run_small(v7a, 3'd6, 32'h7FFF_FFFF, v2a, 1'b1, 32'h7FFF_FFFF, "last");
    run_small(fill7(32'h8000_0000), 3'd0, 32'h8000_0000,
              {32'h8000_0000, 32'h7FFF_FFFF}, 1'b0, 32'h7FFF_FFFF, "first");

    // done_in held high with in changing every cycle: one capture only.
    va = '0;
    va[2*32 +: 32] = 32'd1000;
    in10   = va;
    done10 = 1'b1;
    step();
    pulses    = 0;
    pulse_c   = 0;
    pulse_out = '0;
    for (int c = 1; c <= 24; c++) begin
      vb = '0;
      vb[8*32 +: 32] = 32'(5000 + c);
      in10   = vb;
      done10 = (c < 20);
      step();
      if (v10) begin
        pulses++;
        pulse_c   = c;
        pulse_out = out10;
      end
    end
    chk("held_pulse_count", 64'(pulses), 64'd1);
    chk("held_pulse_cycle", 64'(pulse_c), 64'd4);
    chk("held_out", 64'(pulse_out), 64'd2);

    // Back-to-back starts two cycles apart.
    va = '0;
    va[6*32 +: 32] = 32'd300;
    vb = '0;
    vb[1*32 +: 32] = 32'd300;
    in10   = va;
    done10 = 1'b1;
    step();
    in10   = vb;
    done10 = 1'b0;
    step();
    check_dual(1);
    done10 = 1'b1;
    step();
    check_dual(2);
    done10 = 1'b0;
    in10   = '0;
    for (int c = 3; c <= 8; c++) begin
      step();
      check_dual(c);
    end

    // done_in already high when reset releases counts as a start.
    va = '0;
    va[5*32 +: 32] = 32'd77;
    in10   = va;
    done10 = 1'b1;
    rst    = 1'b1;
    #2;
    chk("rst_async_out", 64'(out10), 64'd0);
    step();
    rst = 1'b0;
    step();
    done10 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk($sformatf("relstart_valid_c%0d", c), 64'(v10), 64'(c == 4));
      if (c >= 4) chk($sformatf("relstart_out_c%0d", c), 64'(out10), 64'd5);
    end

    // Reset two cycles after a start discards the in-flight vector.
    va = '0;
    va[6*32 +: 32] = 32'd42;
    in10   = va;
    done10 = 1'b1;
    step();
    done10 = 1'b0;
    step();
    chk("midrst_pre_out", 64'(out10), 64'd5);
    rst = 1'b1;
    #1;
    chk("midrst_async_out", 64'(out10), 64'd0);
    chk("midrst_async_valid", 64'(v10), 64'd0);
`ifdef OUTPUT_ARGMAX_SCORE_EN
    chk("midrst_async_score", 64'(sc10), 64'd0);
`endif
    step();
    rst = 1'b0;
    for (int c = 3; c <= 10; c++) begin
      step();
      chk($sformatf("midrst_valid_c%0d", c), 64'(v10), 64'd0);
    end
    chk("midrst_final_out", 64'(out10), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
